error_diffusion_dither: RTL
===========================

ERROR_DIFFUSION_DITHER -- requirements
Module: error_diffusion_dither

Interface
REQ-001 SHALL have parameters: H_PIX, default 240, pixels per row; V_PIX, default 320, rows per frame; THRESH, default 64, quantiser threshold.
REQ-002 SHALL have ports (name direction width meaning):
  clk_in  input  1  system clock (65 MHz domain), all logic on its rising edge
  rst_in_n  input  1  reset, asynchronous assert, active-low
  data_in  input  7  grayscale pixel, unsigned 0..127
  hcount_in  input  11  column of data_in, 0..H_PIX-1
  vcount_in  input  10  row of data_in, 0..V_PIX-1
  data_valid_in  input  1  single-cycle strobe, data_in/hcount_in/vcount_in valid
  pixel_out  output  7  dithered pixel, 0 or 127 only
  hcount_out  output  11  column of pixel_out
  vcount_out  output  10  row of pixel_out
  data_valid_out  output  1  single-cycle strobe, outputs valid
  overflow_out  output  1  sticky: an input strobe was dropped
REQ-003 One clock, one reset; no other clocks, enables or handshakes.

Function
REQ-004 SHALL implement Floyd-Steinberg error diffusion, raster order, one pixel per accepted strobe.
REQ-005 Per pixel: acc = data_in + cur_err[h] + carry; all signed 10-bit, saturate to [-128,255].
REQ-006 cur_err[h] SHALL read as 0 when vcount_in==0; carry SHALL be 0 when hcount_in==0.
REQ-007 Quantise: pixel_out = 127 if acc >= THRESH, else 0; err = acc - pixel_out.
REQ-008 Weights, arithmetic shift (floor): r = (7*err)>>>4, dl = (3*err)>>>4, d = (5*err)>>>4, dr = err - r - dl - d (exact error conservation).
REQ-009 carry for next pixel = r; at h==H_PIX-1, r discarded.
REQ-010 Next-row errors via two pending regs pa, pb and one write per pixel: h==0: pa=d, pb=dr, no write; 0<h<H_PIX-1: next_err[h-1]=pa+dl, pa=pb+d, pb=dr; h==H_PIX-1: next_err[h-1]=pa+dl, next_err[h]=pb+d, dr discarded.
REQ-011 At h==0, dl SHALL be discarded.
REQ-012 Row buffers: two H_PIX x 10-bit arrays, ping-pong; roles swap on the accepted strobe with hcount_in==0 and vcount_in!=0. Row V_PIX-1 writes are harmless (masked by REQ-006 next frame).
REQ-013 Latency: data_valid_out, pixel_out, hcount_out, vcount_out exactly 2 cycles after accepted data_valid_in; coordinates pass through unchanged.
REQ-014 Throughput: one strobe accepted per 2 cycles. A strobe arriving 1 cycle after an accepted strobe SHALL be dropped (no output, no state change) and set overflow_out=1.
REQ-015 Out-of-range hcount_in/vcount_in strobes SHALL be dropped, overflow_out unchanged, no output.
REQ-016 No assumption on row/column continuity beyond REQ-006/REQ-012; missing pixels leave stale buffer entries (no error reported).
REQ-017 Outputs between strobes hold last value except data_valid_out, which is 0.

Reset
REQ-018 rst_in_n low SHALL asynchronously clear pixel_out, hcount_out, vcount_out, data_valid_out, overflow_out, carry, pa, pb, pipeline valid bits, ping-pong select to 0.
REQ-019 Row buffer contents need not be reset; REQ-006 masks them on the first row.
REQ-020 Reset mid-pipeline SHALL cancel in-flight pixels; no data_valid_out for them after release.
REQ-021 overflow_out clears only on reset.

Verification
REQ-022 Flat 64 frame, strobes every 4 cycles: first pixel (0,0) -> 127 at +2 cycles; golden model match for all 76800 pixels; per-row mean of output within 1 of 64.
REQ-023 All-0 frame -> all outputs 0; all-127 frame -> all outputs 127; overflow_out stays 0.
REQ-024 Single pixel 100 at (0,0), rest 0 (row 0): err=-27 -> r=-12, pixel (1,0)=0, next_err[0]=d+... matches golden; h==0 dl discard checked.
REQ-025 Two strobes 1 cycle apart -> second dropped, only one data_valid_out, overflow_out=1 and held.
REQ-026 Frame 2 after random frame 1 with stale buffers -> row 0 outputs equal fresh-start golden.
REQ-027 rst_in_n pulsed 1 cycle after a strobe -> no output for it; all outputs 0 immediately; next frame matches golden.

Source files
------------

// File: rtl/error_diffusion_dither.sv
// Floyd-Steinberg error-diffusion dither: 7-bit grayscale in, 0/127 out.
// Stage 1 latches an accepted strobe; stage 2 reads the current-row error,
// quantises, spreads the error to the right/next row and drives the outputs.
module error_diffusion_dither #(
    parameter int H_PIX  = 240,
    parameter int V_PIX  = 320,
    parameter int THRESH = 64
) (
    input  logic        clk_in,
    input  logic        rst_in_n,
    input  logic [6:0]  data_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        data_valid_in,
    output logic [6:0]  pixel_out,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        data_valid_out,
    output logic        overflow_out
);
    localparam int AW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    localparam logic [10:0]       H_LIM    = 11'(H_PIX);
    localparam logic [10:0]       H_LAST   = 11'(H_PIX - 1);
    localparam logic [9:0]        V_LIM    = 10'(V_PIX);
    localparam logic signed [9:0] THRESH_S = 10'(THRESH);
    localparam logic [AW-1:0]     ONE_A    = AW'(1);

    // Ping-pong row buffers: [sel_q] holds this row's errors, [~sel_q] collects the next row's.
    logic signed [9:0] row_buf [2][H_PIX];

    logic              s1_valid_q, s1_valid_d;
    logic [6:0]        s1_data_q, s1_data_d;
    logic [10:0]       s1_h_q, s1_h_d;
    logic [9:0]        s1_v_q, s1_v_d;
    logic              sel_q, sel_d;
    logic signed [9:0] carry_q, carry_d;
    logic signed [9:0] pa_q, pa_d;
    logic signed [9:0] pb_q, pb_d;
    logic [6:0]        pixel_q, pixel_d;
    logic [10:0]       hcount_q, hcount_d;
    logic [9:0]        vcount_q, vcount_d;
    logic              dv_q, dv_d;
    logic              ovf_q, ovf_d;

    logic              in_range, accept;
    logic [AW-1:0]     rd_addr;
    logic signed [9:0] cur_err, carry_in;
    logic signed [11:0] data_ext, cur_ext, car_ext, acc_sum;
    logic signed [9:0] acc, err;
    logic              quant_hi;
    logic signed [13:0] err_w;
    logic signed [9:0] r_w, dl_w, d_w, dr_w;
    logic              we_a, we_b;
    logic [AW-1:0]     addr_a, addr_b;
    logic signed [9:0] wdata_a, wdata_b;

    // Input acceptance: in-range strobes only, and never while stage 1 is still occupied.
    always_comb begin
        in_range   = (hcount_in < H_LIM) && (vcount_in < V_LIM);
        accept     = data_valid_in && in_range && !s1_valid_q;
        s1_valid_d = accept;
        s1_data_d  = s1_data_q;
        s1_h_d     = s1_h_q;
        s1_v_d     = s1_v_q;
        sel_d      = sel_q;
        ovf_d      = ovf_q | (data_valid_in & s1_valid_q);
        if (accept) begin
            s1_data_d = data_in;
            s1_h_d    = hcount_in;
            s1_v_d    = vcount_in;
            if (hcount_in == 11'd0 && vcount_in != 10'd0) begin
                sel_d = ~sel_q;
            end
        end
    end

    // Quantise one pixel and spread its error; next-row entries are finalised one column behind.
    always_comb begin
        rd_addr  = s1_h_q[AW-1:0];
        cur_err  = (s1_v_q == 10'd0) ? 10'sd0 : row_buf[sel_q][rd_addr];
        carry_in = (s1_h_q == 11'd0) ? 10'sd0 : carry_q;
        data_ext = $signed({5'b0, s1_data_q});
        cur_ext  = {{2{cur_err[9]}}, cur_err};
        car_ext  = {{2{carry_in[9]}}, carry_in};
        acc_sum  = data_ext + cur_ext + car_ext;
        if (acc_sum > 12'sd255) begin
            acc = 10'sd255;
        end else if (acc_sum < -12'sd128) begin
            acc = -10'sd128;
        end else begin
            acc = 10'(acc_sum);
        end
        quant_hi = (acc >= THRESH_S);
        err      = quant_hi ? (acc - 10'sd127) : acc;
        err_w    = {{4{err[9]}}, err};
        r_w      = 10'((err_w * 14'sd7) >>> 4);
        dl_w     = 10'((err_w * 14'sd3) >>> 4);
        d_w      = 10'((err_w * 14'sd5) >>> 4);
        dr_w     = err - r_w - dl_w - d_w;

        carry_d  = carry_q;
        pa_d     = pa_q;
        pb_d     = pb_q;
        pixel_d  = pixel_q;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        dv_d     = s1_valid_q;
        we_a     = 1'b0;
        we_b     = 1'b0;
        addr_a   = rd_addr - ONE_A;
        addr_b   = rd_addr;
        wdata_a  = pa_q + dl_w;
        wdata_b  = pb_q + d_w;
        if (s1_valid_q) begin
            pixel_d  = quant_hi ? 7'd127 : 7'd0;
            hcount_d = s1_h_q;
            vcount_d = s1_v_q;
            if (s1_h_q == 11'd0) begin
                pa_d    = d_w;
                pb_d    = dr_w;
                carry_d = r_w;
            end else if (s1_h_q == H_LAST) begin
                we_a    = 1'b1;
                we_b    = 1'b1;
                carry_d = 10'sd0;
            end else begin
                we_a    = 1'b1;
                pa_d    = pb_q + d_w;
                pb_d    = dr_w;
                carry_d = r_w;
            end
        end
    end

    // Pipeline, diffusion state and output registers.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_h_q     <= '0;
            s1_v_q     <= '0;
            sel_q      <= 1'b0;
            carry_q    <= '0;
            pa_q       <= '0;
            pb_q       <= '0;
            pixel_q    <= '0;
            hcount_q   <= '0;
            vcount_q   <= '0;
            dv_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_h_q     <= s1_h_d;
            s1_v_q     <= s1_v_d;
            sel_q      <= sel_d;
            carry_q    <= carry_d;
            pa_q       <= pa_d;
            pb_q       <= pb_d;
            pixel_q    <= pixel_d;
            hcount_q   <= hcount_d;
            vcount_q   <= vcount_d;
            dv_q       <= dv_d;
            ovf_q      <= ovf_d;
        end
    end

    // Next-row buffer writes; contents are masked on row 0 so they need no reset.
    always_ff @(posedge clk_in) begin
        if (we_a) row_buf[~sel_q][addr_a] <= wdata_a;
        if (we_b) row_buf[~sel_q][addr_b] <= wdata_b;
    end

    assign pixel_out      = pixel_q;
    assign hcount_out     = hcount_q;
    assign vcount_out     = vcount_q;
    assign data_valid_out = dv_q;
    assign overflow_out   = ovf_q;

endmodule
